// File: rtl/bus_arbiter_if.sv
// Bundle of request/grant/ack lines between two bus masters, the addressed slave and the arbiter.
// The arbiter connects through "master" (it drives the grant side); the agents use "slave".
interface bus_arbiter_if;
    logic       m0_req;
    logic       m1_req;
    logic       s_ack;
    logic       m0_gnt;
    logic       m1_gnt;
    logic       m0_done;
    logic       m1_done;
    logic [1:0] sel_master;
    logic       bus_busy;
    logic       timeout_err;
    logic       hold_flag;

    modport master (
        input  m0_req, m1_req, s_ack,
        output m0_gnt, m1_gnt, m0_done, m1_done, sel_master, bus_busy, timeout_err, hold_flag
    );

    modport slave (
        output m0_req, m1_req, s_ack,
        input  m0_gnt, m1_gnt, m0_done, m1_done, sel_master, bus_busy, timeout_err, hold_flag
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter (LSU = m0, fetch = m1) with zero-bubble handoff and ack timeout.
// Define ARB_RR_EN for round-robin between simultaneous requests; otherwise m0 has fixed priority.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       m0_done_q;
    logic       m1_done_q;
    logic       timeout_q;
    logic       finish;
    logic       timed_out;
    logic       prefer_m1;

`ifdef ARB_RR_EN
    logic last_m1;
    assign prefer_m1 = ~last_m1;
`else
    assign prefer_m1 = 1'b0;
`endif

    function automatic state_t arbitrate(logic r0, logic r1, logic pick_m1);
        if (r0 && r1) return pick_m1 ? OWN1 : OWN0;
        if (r0)       return OWN0;
        if (r1)       return OWN1;
        return IDLE;
    endfunction

    // The finishing master's own request is masked so the other side gets the bus first.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        next_state = state;
        timed_out  = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: next_state = arbitrate(bus.m0_req, bus.m1_req, prefer_m1);
            OWN0: begin
                timed_out = !bus.s_ack && (wait_cnt == LIMIT);
                finish    = bus.s_ack || timed_out;
                if (finish) next_state = arbitrate(1'b0, bus.m1_req, prefer_m1);
            end
            OWN1: begin
                timed_out = !bus.s_ack && (wait_cnt == LIMIT);
                finish    = bus.s_ack || timed_out;
                if (finish) next_state = arbitrate(bus.m0_req, 1'b0, prefer_m1);
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
            timeout_q <= 1'b0;
`ifdef ARB_RR_EN
            last_m1   <= 1'b1;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
            state     <= next_state;
            m0_done_q <= (state == OWN0) && finish;
            m1_done_q <= (state == OWN1) && finish;
            timeout_q <= timed_out;
            if (next_state == IDLE || next_state != state) wait_cnt <= '0;
            else                                           wait_cnt <= wait_cnt + 8'd1;
`ifdef ARB_RR_EN
            if (next_state == OWN0 && state != OWN0)      last_m1 <= 1'b0;
            else if (next_state == OWN1 && state != OWN1) last_m1 <= 1'b1;
`endif
        end
    end

    assign bus.m0_gnt      = (state == OWN0);
    assign bus.m1_gnt      = (state == OWN1);
    assign bus.sel_master  = {state == OWN1, state == OWN0};
    assign bus.bus_busy    = (state != IDLE);
    assign bus.m0_done     = m0_done_q;
    assign bus.m1_done     = m1_done_q;
    assign bus.timeout_err = timeout_q;
    assign bus.hold_flag   = (bus.m0_req && !m0_done_q) || (state == OWN0);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios plus randomized req/ack traffic,
// checked against an ownership-level reference model.
module tb_bus_arbiter;

    localparam int unsigned TIMEOUT = 4;
`ifdef ARB_RR_EN
    localparam bit RR_ON = 1'b1;
`else
    localparam bit RR_ON = 1'b0;
`endif

    typedef logic [8:0] vec_t; // {g0, g1, sel[1:0], busy, d0, d1, to, hold}

    logic clk = 1'b0;
    logic rst = 1'b1;
    bus_arbiter_if bus ();

    bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t sb_q[$];

    // Reference model: who owns the bus, how long it has owned it, and who was served last.
    int   m_own  = 0;     // 0 none, 1 m0, 2 m1
    int   m_age  = 0;     // completed owned cycles before the current one
    int   m_last = 2;
    logic m_d0   = 1'b0;
    logic m_d1   = 1'b0;
    logic m_to   = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic a0, input logic a1);
        if (a0 && a1) return (RR_ON && m_last == 1) ? 2 : 1;
        if (a0) return 1;
        if (a1) return 2;
        return 0;
    endfunction

    task automatic grant(input int who);
        if (who != 0) begin
            m_own  = who;
            m_age  = 0;
            m_last = who;
        end
    endtask

    task automatic model_cycle(input logic r, input logic a0, input logic a1, input logic ack);
        int other;
        m_d0 = 1'b0;
        m_d1 = 1'b0;
        m_to = 1'b0;
        if (r) begin
            m_own  = 0;
            m_age  = 0;
            m_last = 2;
        end else if (m_own == 0) begin
            grant(pick(a0, a1));
        end else if (ack || (m_age + 1 == int'(TIMEOUT))) begin
            if (m_own == 1) m_d0 = 1'b1;
            else            m_d1 = 1'b1;
            m_to  = !ack;
            other = (m_own == 1) ? (a1 ? 2 : 0) : (a0 ? 1 : 0);
            m_own = 0;
            grant(other);
        end else begin
            m_age++;
        end
    endtask

    function automatic vec_t expected(input logic a0);
        logic g0, g1;
        g0 = (m_own == 1);
        g1 = (m_own == 2);
        return {g0, g1, g1, g0, m_own != 0, m_d0, m_d1, m_to, (a0 && !m_d0) || g0};
    endfunction

    task automatic step(input logic r, input logic a0, input logic a1, input logic ack);
        @(negedge clk);
        rst        = r;
        bus.m0_req = a0;
        bus.m1_req = a1;
        bus.s_ack  = ack;
        model_cycle(r, a0, a1, ack);
        sb_q.push_back(expected(a0));
        if (r) begin
            #1;
            check("gnt_drop_on_rst", 16'({bus.m0_gnt, bus.m1_gnt}), 16'd0);
        end
    endtask

    // Monitor: every cycle the DUT presents a fresh output set just after the rising edge.
    initial begin
        vec_t act;
        vec_t exp;
        logic prev_g0 = 1'b0;
        logic prev_g1 = 1'b0;
        wait (sb_q.size() != 0);
        forever begin
            @(posedge clk);
            #1;
            act = {bus.m0_gnt, bus.m1_gnt, bus.sel_master, bus.bus_busy,
                   bus.m0_done, bus.m1_done, bus.timeout_err, bus.hold_flag};
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underflow @%0t: no expected entry for actual=%b", $time, act);
            end else begin
                exp = sb_q.pop_front();
                check("outputs{g0,g1,sel,busy,d0,d1,to,hold}", 16'(act), 16'(exp));
            end
            check("gnt_mutex", 16'(bus.m0_gnt & bus.m1_gnt), 16'd0);
            check("done_mutex", 16'(bus.m0_done & bus.m1_done), 16'd0);
            if (!rst) begin
                check("m0_interval_done", 16'(bus.m0_done), 16'(prev_g0 & !bus.m0_gnt));
                check("m1_interval_done", 16'(bus.m1_done), 16'(prev_g1 & !bus.m1_gnt));
                prev_g0 = bus.m0_gnt;
                prev_g1 = bus.m1_gnt;
            end else begin
                prev_g0 = 1'b0;
                prev_g1 = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic cur0, cur1, ack, r;
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        bus.s_ack  = 1'b0;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Single m1 transaction, ack on the third owned cycle, release in done cycle.
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);

        // Both masters hold requests, slave acks every cycle: back-to-back alternating rounds.
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // m0 served alone, then a simultaneous request exposes the arbitration policy.
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        step(0, 1, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Timeout: m0 granted, slave never acks.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Ack while idle is ignored.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Reset during an m1 ownership, m1 keeps requesting across it.
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);

        // Randomized traffic honouring the hold-until-done request protocol.
        cur0 = 1'b0;
        cur1 = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (m_d0)       cur0 = 1'($urandom_range(0, 1));
            else if (!cur0) cur0 = ($urandom_range(0, 3) == 0);
            if (m_d1)       cur1 = 1'($urandom_range(0, 1));
            else if (!cur1) cur1 = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 9) < 3);
            r   = ($urandom_range(0, 299) == 0);
            step(r, cur0, cur1, ack);
        end
        step(0, 0, 0, 0);

        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
